// File: rtl/basic_i2s_transmit_pkg.sv
// Shared defaults and channel encoding for the I2S transmitter.
// Imported by the synchroniser and the top level.
package basic_i2s_transmit_pkg;

    localparam int I2S_DATA_WIDTH  = 32;
    localparam int I2S_SYNC_STAGES = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_chan_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level input.
// Provides the synced level plus one-clk rise/fall pulses.
module i2s_sync_edge
    import basic_i2s_transmit_pkg::*;
#(
    parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = prev & ~level;

endmodule

// File: rtl/basic_i2s_transmit.sv
// Philips I2S transmitter, slave to external sck/ws.
// Loads a channel word on each ws change and shifts it out MSB-first.
module basic_i2s_transmit
    import basic_i2s_transmit_pkg::*;
#(
    parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
    parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ws,
    input  logic [DATA_WIDTH-1:0] data_left,
    input  logic [DATA_WIDTH-1:0] data_right,
    output logic                  sd
);

    logic                  sck_s;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  ws_s;
    logic                  ws_rise;
    logic                  ws_fall;
    logic                  ws_prev;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  unused_edges;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .level(sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ws_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ws),
        .level(ws_s),
        .rise (ws_rise),
        .fall (ws_fall)
    );

    // ws is judged against its value at the previous sck fall, not per clk
    assign unused_edges = ^{sck_s, sck_rise, ws_rise, ws_fall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_prev   <= 1'b0;
            shift_reg <= '0;
            sd        <= 1'b0;
        end else if (sck_fall) begin
            ws_prev <= ws_s;
            sd      <= shift_reg[DATA_WIDTH-1];
            if (ws_s != ws_prev) begin
                shift_reg <= (i2s_chan_e'(ws_s) == CH_RIGHT) ? data_right
                                                             : data_left;
            end else begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_basic_i2s_transmit.sv
// Scoreboard bench: stimulus queues expected words per ws frame,
// a receiver-style monitor rebuilds words from sd and compares.
module tb_basic_i2s_transmit;

    logic        clk;
    logic        rst;
    logic        sck;
    logic        ws;
    logic [31:0] data_left;
    logic [31:0] data_right;
    logic        sd;

    int n_tests    = 0;
    int n_fail     = 0;
    int n_pushed   = 0;
    int n_aborted  = 0;
    int words_done = 0;

    logic [31:0] exp_q[$];

    basic_i2s_transmit #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ws        (ws),
        .data_left (data_left),
        .data_right(data_right),
        .sd        (sd)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Receiver model: a word's MSB is read at the 2nd sck fall after
    // the ws change, one bit per fall, LSB at the 1st fall of next frame.
    logic        mon_ws;
    int          mon_k;
    bit          mon_active;
    int          mon_nb;
    logic [31:0] mon_acc;
    logic [31:0] mon_exp;

    initial begin
        mon_ws     = 1'b0;
        mon_k      = 100;
        mon_active = 1'b0;
        mon_nb     = 0;
        mon_acc    = '0;
        mon_exp    = '0;
        forever begin
            @(negedge sck);
            if (ws !== mon_ws) begin
                mon_k  = 0;
                mon_ws = ws;
            end else begin
                mon_k++;
            end
            if (rst) begin
                mon_active = 1'b0;
                continue;
            end
            if (mon_k == 2 && !mon_active && exp_q.size() > 0) begin
                mon_exp    = exp_q.pop_front();
                mon_active = 1'b1;
                mon_nb     = 0;
                mon_acc    = '0;
            end
            if (mon_active) begin
                mon_acc = {mon_acc[30:0], sd};
                mon_nb++;
                if (mon_nb == 32) begin
                    check("word", mon_acc, mon_exp);
                    words_done++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic sck_period();
        sck = 1'b0;
        #40;
        sck = 1'b1;
        #40;
    endtask

    function automatic logic [31:0] len_mask(input int len);
        logic [31:0] m;
        m = '1;
        m = m << (32 - len);
        return m;
    endfunction

    // One 32-sck ws half-cycle; data presented together with the ws edge.
    task automatic frame(input logic ch, input logic [31:0] d,
                         input bit chg, input bit lead_chk);
        logic [31:0] other;
        other = $urandom;
        ws    = ch;
        if (ch) begin
            data_right = d;
            data_left  = other;
        end else begin
            data_left  = d;
            data_right = other;
        end
        exp_q.push_back(d);
        n_pushed++;
        for (int i = 0; i < 32; i++) begin
            if (lead_chk && i == 1) check("lead_zero", {31'b0, sd}, 32'd0);
            if (chg && i == 10) begin
                if (ch) data_right = ~d;
                else    data_left  = ~d;
            end
            sck_period();
        end
    endtask

    initial begin
        logic        ch;
        logic [31:0] d;
        rst        = 1'b1;
        sck        = 1'b1;
        ws         = 1'b0;
        data_left  = 32'hDEAD_BEEF;
        data_right = 32'h1234_5678;
        #5;
        for (int i = 0; i < 3; i++) begin
            sck = 1'b0;
            #1 check("reset_sd", {31'b0, sd}, 32'd0);
            #39 sck = 1'b1;
            #40;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("pre_ws_rise_sd", {31'b0, sd}, 32'd0);
            sck_period();
        end

        frame(1'b1, 32'hA5A5_F00F, 1'b0, 1'b1);
        frame(1'b0, 32'h8000_0001, 1'b0, 1'b0);

        ch = 1'b1;
        for (int len = 3; len <= 32; len++) begin
            for (int r = 0; r < 2; r++) begin
                d = $urandom;
                d = d & len_mask(len);
                frame(ch, d, 1'b0, 1'b0);
                ch = ~ch;
            end
        end

        frame(1'b1, $urandom, 1'b1, 1'b0);
        frame(1'b0, $urandom, 1'b1, 1'b0);

        // Right word interrupted by reset around bit 10
        d          = $urandom | 32'h8000_0000;
        ws         = 1'b1;
        data_right = d;
        data_left  = $urandom;
        exp_q.push_back(d);
        n_pushed++;
        n_aborted++;
        for (int i = 0; i < 32; i++) begin
            sck = 1'b0;
            if (i == 11) begin
                #20 rst = 1'b1;
                exp_q.delete();
                #1 check("rst_mid_sd", {31'b0, sd}, 32'd0);
                #19;
            end else if (i == 12 || i == 13) begin
                #1 check("rst_hold_sd", {31'b0, sd}, 32'd0);
                #39;
            end else if (i == 14) begin
                #20 rst = 1'b0;
                #20;
            end else begin
                #40;
            end
            sck = 1'b1;
            #40;
        end
        frame(1'b0, 32'hC3C3_5AA5, 1'b0, 1'b0);
        frame(1'b1, $urandom, 1'b0, 1'b0);

        ws        = 1'b0;
        data_left = 32'h0;
        for (int i = 0; i < 4; i++) sck_period();

        check("queue_empty", exp_q.size(), 32'd0);
        check("words_done", words_done, n_pushed - n_aborted);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
